// File: rtl/i2c_pkg.sv
// -----------------------------------------------------------------------------
// i2c_pkg: shared types and constants for the I2C responder.
//   i2c_state_e      - protocol FSM states
//   COND_*           - bus condition codes from the synchronizer/detector
//   BIT_ACK/BIT_NACK - sda level of the ninth (acknowledge) bit
//   addr_hit()       - address-match helper, general call included on request
// -----------------------------------------------------------------------------
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    WAIT_STOP
  } i2c_state_e;

  localparam logic [1:0] COND_NONE  = 2'd0;
  localparam logic [1:0] COND_START = 2'd1;
  localparam logic [1:0] COND_STOP  = 2'd2;

  localparam logic BIT_ACK  = 1'b0;
  localparam logic BIT_NACK = 1'b1;

  // General call (address 0) is only ever a write; a read to it is not ours.
  function automatic logic addr_hit(input logic [6:0] addr,
                                    input logic [6:0] own,
                                    input logic       rw,
                                    input logic       gc_en);
    return (addr == own) || (gc_en && (addr == 7'h00) && (rw == 1'b0));
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// -----------------------------------------------------------------------------
// i2c_bus_sync: synchronizes scl/sda into the clk domain and detects scl edges
// and START/STOP conditions from the synchronized values only.
//   clk, reset_n        - system clock, async active-low reset
//   scl, sda            - raw bus lines
//   sda_s               - synchronized sda
//   scl_rise, scl_fall  - one-clk scl edge strobes
//   cond                - COND_START / COND_STOP / COND_NONE for this clk
// -----------------------------------------------------------------------------
module i2c_bus_sync
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl,
  input  logic       sda,
  output logic       sda_s,
  output logic       scl_rise,
  output logic       scl_fall,
  output logic [1:0] cond
);

  logic [SYNC_STAGES-1:0] scl_ff;
  logic [SYNC_STAGES-1:0] sda_ff;
  logic                   scl_s;
  logic                   scl_d;
  logic                   sda_d;
  // Fills with ones after reset; edges are ignored until the chain and the
  // delayed copies hold real bus values, so the preset cannot fake a START.
  logic [SYNC_STAGES:0]   primed;
  logic                   live;

  // NOTE: all clocked state uses non-blocking assignment so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse stages.
  // The chain presets to 1 so reset looks like an idle (released) bus.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      scl_ff <= '1;
      sda_ff <= '1;
      scl_d  <= 1'b1;
      sda_d  <= 1'b1;
      primed <= '0;
    end else begin
      scl_ff <= {scl_ff[SYNC_STAGES-2:0], scl};
      sda_ff <= {sda_ff[SYNC_STAGES-2:0], sda};
      scl_d  <= scl_s;
      sda_d  <= sda_s;
      primed <= {primed[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign scl_s    = scl_ff[SYNC_STAGES-1];
  assign sda_s    = sda_ff[SYNC_STAGES-1];
  assign live     = primed[SYNC_STAGES];
  assign scl_rise = live & scl_s & ~scl_d;
  assign scl_fall = live & ~scl_s & scl_d;

  // NOTE: the output gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    cond = COND_NONE;
    if (live && scl_s && scl_d) begin
      if (sda_d && !sda_s)      cond = COND_START;
      else if (!sda_d && sda_s) cond = COND_STOP;
    end
  end

endmodule

// File: rtl/i2c_slave.sv
// -----------------------------------------------------------------------------
// i2c_slave: 7-bit-address I2C responder with byte-wide write/read interface.
//   clk, reset_n  - system clock (>= 8x scl), async active-low reset
//   i2c_scl       - bus clock from the master
//   i2c_sda       - open-drain bus data; driven 0 or released, never 1
//   tx_data       - byte returned on a master read, latched 1 clk after tx_req
//   tx_req        - one-clk request for the next read byte
//   rx_data       - last byte written by the master
//   rx_valid      - one-clk strobe when rx_data is updated
//   busy          - high from an address match until STOP/rep. START/NACK
// Build option: define I2C_SLAVE_GEN_CALL_EN to also accept the general-call
// write (address 7'h00, rw=0).
// -----------------------------------------------------------------------------
module i2c_slave
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR  = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i2c_scl,
  inout  wire        i2c_sda,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy
);

`ifdef I2C_SLAVE_GEN_CALL_EN
  localparam logic GEN_CALL_EN = 1'b1;
`else
  localparam logic GEN_CALL_EN = 1'b0;
`endif

  logic       sda_s, scl_rise, scl_fall;
  logic [1:0] cond;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .scl      (i2c_scl),
    .sda      (i2c_sda),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .cond     (cond)
  );

  i2c_state_e state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [6:0] shreg, shreg_n;       // first seven bits; the eighth is sda_s
  logic       got_byte, got_byte_n; // eight bits taken, waiting for scl fall
  logic       rw, rw_n;
  logic       match, match_n;
  logic       sda_oe, sda_oe_n;     // 1 = pull sda low
  logic [7:0] tx_byte, tx_byte_n;
  logic [7:0] rx_data_n;
  logic       rx_valid_n, tx_req_n, busy_n;
  logic [7:0] byte_in;
  logic       hit;

  assign byte_in = {shreg, sda_s};
  assign hit     = addr_hit(shreg, SLAVE_ADDR, sda_s, GEN_CALL_EN);
  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_n;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      got_byte <= 1'b0;
      rw       <= 1'b0;
      match    <= 1'b0;
      sda_oe   <= 1'b0;
      tx_byte  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      tx_req   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      got_byte <= got_byte_n;
      rw       <= rw_n;
      match    <= match_n;
      sda_oe   <= sda_oe_n;
      tx_byte  <= tx_byte_n;
      rx_data  <= rx_data_n;
      rx_valid <= rx_valid_n;
      tx_req   <= tx_req_n;
      busy     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    got_byte_n = got_byte;
    rw_n       = rw;
    match_n    = match;
    sda_oe_n   = sda_oe;
    tx_byte_n  = tx_req ? tx_data : tx_byte;
    rx_data_n  = rx_data;
    rx_valid_n = 1'b0;
    tx_req_n   = 1'b0;
    busy_n     = busy;

    // Bus conditions outrank any scl edge on the same clk and abort the byte.
    if (cond == COND_START) begin
      state_n    = ADDR;
      bit_cnt_n  = '0;
      got_byte_n = 1'b0;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
    end else if (cond == COND_STOP) begin
      state_n    = IDLE;
      got_byte_n = 1'b0;
      sda_oe_n   = 1'b0;
      busy_n     = 1'b0;
    end else begin
      unique case (state)
        ADDR: begin
          if (scl_rise) begin
            shreg_n   = byte_in[6:0];
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              got_byte_n = 1'b1;
              rw_n       = sda_s;
              match_n    = hit;
              if (hit) begin
                busy_n   = 1'b1;
                tx_req_n = sda_s;
              end
            end
          end else if (scl_fall && got_byte) begin
            got_byte_n = 1'b0;
            if (match) begin
              state_n  = ADDR_ACK;
              sda_oe_n = 1'b1;
            end else begin
              state_n  = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            state_n  = rw ? RD_DATA : WR_DATA;
            sda_oe_n = rw ? ~tx_byte[7] : 1'b0;
          end
        end
        WR_DATA: begin
          if (scl_rise) begin
            shreg_n   = byte_in[6:0];
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              rx_data_n  = byte_in;
              rx_valid_n = 1'b1;
              got_byte_n = 1'b1;
            end
          end else if (scl_fall && got_byte) begin
            state_n    = WR_ACK;
            sda_oe_n   = 1'b1;
            got_byte_n = 1'b0;
          end
        end
        WR_ACK: begin
          if (scl_fall) begin
            state_n  = WR_DATA;
            sda_oe_n = 1'b0;
          end
        end
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) got_byte_n = 1'b1;
          end else if (scl_fall) begin
            if (got_byte) begin
              state_n    = RD_ACK;
              sda_oe_n   = 1'b0;
              got_byte_n = 1'b0;
            end else begin
              // ~bit_cnt == 7 - bit_cnt: MSB first
              sda_oe_n = ~tx_byte[~bit_cnt];
            end
          end
        end
        RD_ACK: begin
          if (scl_rise) begin
            if (sda_s == BIT_ACK) begin
              state_n  = RD_DATA;
              tx_req_n = 1'b1;
            end else begin
              state_n = WAIT_STOP;
              busy_n  = 1'b0;
            end
          end
        end
        default: ; // IDLE, WAIT_STOP: only a bus condition moves us on
      endcase
    end
  end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 Parameter SLAVE_ADDR, default 7'h50, is the 7-bit bus address this responder answers.
REQ-002 Parameter SYNC_STAGES, default 2, is the number of input synchronizer flops on scl and sda (legal range 2..3).
REQ-003 clk  input  1  system clock; oversamples the bus, with frequency at least 8x the SCL frequency.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 i2c_scl  input  1  bus clock from the master.
REQ-006 i2c_sda  inout  1  bus data, open-drain: the block drives 0 or 'bz, never 1.
REQ-007 tx_data  input  8  byte to return on a master read; sampled when tx_req is high.
REQ-008 tx_req  output  1  one-clk pulse requesting the next read byte.
REQ-009 rx_data  output  8  last byte written by the master; held until the next write byte.
REQ-010 rx_valid  output  1  one-clk pulse when rx_data is updated.
REQ-011 busy  output  1  high from an address match until STOP, repeated START or NACK termination.

Function
REQ-012 scl and sda shall pass through SYNC_STAGES flops; all edge and condition detection shall use the synchronized values only.
REQ-013 START is synchronized sda 1->0 while scl is high; STOP is sda 0->1 while scl is high; each is detected within SYNC_STAGES+1 clk of the bus event.
REQ-014 State enum values: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
REQ-015 START from any state goes to ADDR with the bit counter cleared; this covers repeated START.
REQ-016 STOP from any state goes to IDLE.
REQ-017 Bus bits are sampled on the synchronized scl rising edge, MSB first.
REQ-018 Driven sda changes only on the clk after a detected scl falling edge.
REQ-019 ADDR shifts in 8 bits (address[6:0], then rw).
- On a match, at the next scl fall: go to ADDR_ACK and drive sda=0.
- On a mismatch: go to WAIT_STOP and leave sda released.
REQ-020 ADDR_ACK releases sda at the following scl fall.
- rw=0: go to WR_DATA.
- rw=1: go to RD_DATA and drive bit 7 of the byte latched from tx_data.
REQ-021 tx_req pulses on the clk on which the address match is decided with rw=1, and again on the clk on which the master ACK is sampled in RD_ACK; tx_data is latched 1 clk after tx_req.
REQ-022 WR_DATA shifts in 8 bits, then moves to WR_ACK at the scl fall.
- rx_data is loaded and rx_valid pulses on the 8th scl rise.
- WR_ACK drives sda=0 for one scl period and returns to WR_DATA.
REQ-023 RD_DATA shifts out 8 bits, then moves to RD_ACK and releases sda.
- RD_ACK samples sda at the scl rise.
- sda=0 (ACK): go to RD_DATA.
- sda=1 (NACK): go to WAIT_STOP.
REQ-024 The bit counter is 3 bits wide and wraps from 7 to 0 at each byte boundary.
REQ-025 If START or STOP coincides with an scl edge event on the same clk, the condition wins.
REQ-026 A START or STOP arriving mid-byte aborts the byte: rx_valid does not pulse and sda is released the same clk.

Reset
REQ-027 While reset_n is low: state=IDLE, sda released, rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, synchronizers preset to 1.
REQ-028 Reset deassertion mid-transfer leaves the block in IDLE, ignoring the bus until the next START.

Configuration
REQ-029 With I2C_SLAVE_GEN_CALL_EN defined, address 7'h00 with rw=0 is also ACKed and handled as a write; read to 7'h00 is NACKed.
REQ-030 With I2C_SLAVE_GEN_CALL_EN undefined, address 7'h00 is treated as a mismatch.

Structure
REQ-031 Package i2c_pkg holds the state enum typedef and the START/STOP/ACK/NACK constants.
REQ-032 A sub-module i2c_bus_sync holds the synchronizer and the edge/START/STOP detector.
REQ-033 The implementation totals 150-300 lines of RTL.

Verification
REQ-034 Write 0x50/W + byte 0xA5 + STOP -> address ACK, data ACK, rx_data=8'hA5, one rx_valid pulse, busy falls after STOP.
REQ-035 Address 0x51/W -> no ACK (sda stays 1 in the 9th bit), busy=0, no rx_valid.
REQ-036 Read 0x50/R with tx_data=8'h3C then 8'hC3, master ACK then NACK -> bus bytes 3C, C3; two tx_req pulses; sda released; WAIT_STOP.
REQ-037 Write 0x50/W + 0x11, repeated START + 0x50/R -> rx_data=8'h11, then a read byte is served without a STOP in between.
REQ-038 reset_n pulsed low during the 4th data bit -> sda released immediately, all outputs at reset values, the next START is served normally.
REQ-039 General call 0x00/W + 0x06 -> ACK and rx_data=8'h06 only when I2C_SLAVE_GEN_CALL_EN is defined; otherwise NACK.
